dsp_chain_sop_array: RTL and testbench

- Parametrised, multi-lane successor to the fixed 8-instance, 4-term DSP-chain sum-of-products wrapper.
- Each lane computes a signed sum of TERMS products through a cascaded, DSP-chain-style pipeline with internal input skew.
- Adds valid tracking, multi-beat accumulation mode, and saturating or wrapping overflow with a per-lane overflow flag.
- Sits in the proxy-benchmark datapath wherever banks of dot-product units feed downstream reduction logic.

---
 rtl/dsp_chain_sop_array_pkg.sv | 39 +++
 rtl/dsp_chain_sop_array_if.sv | 28 ++
 rtl/dsp_chain_sop_array_lane.sv | 101 ++++++++++
 rtl/dsp_chain_sop_array.sv | 56 +++++
 tb/tb_dsp_chain_sop_array.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_chain_sop_array_pkg.sv
// Shared types and elaboration helpers for the multi-lane DSP-chain sum-of-products array.
// Latency helper, width helpers and the per-beat control word carried alongside the datapath.
package dsp_sop_pkg;

   typedef struct packed {
      logic valid;
      logic acc_en;
      logic acc_last;
   } ctrl_t;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

   function automatic int sop_latency(input int terms);
      return terms + 2;
   endfunction

   // Smallest result width that holds a full chain sum without overflow.
   function automatic int chain_width(input int a_w, input int b_w, input int terms);
      return a_w + b_w + clog2(terms);
   endfunction

   localparam int DEF_LANES = 8;
   localparam int DEF_TERMS = 4;
   localparam int DEF_A_W   = 18;
   localparam int DEF_B_W   = 19;
   // One headroom bit above the chain width, so a lone beat never saturates.
   localparam int DEF_OUT_W = chain_width(DEF_A_W, DEF_B_W, DEF_TERMS) + 1;

endpackage

// File: rtl/dsp_chain_sop_array_if.sv
// Beat-level bus of the sum-of-products array: operands and group control in, lane results out.
// No backpressure; master drives one beat per cycle at most.
interface dsp_chain_sop_array_if #(
   parameter int LANES = 8,
   parameter int TERMS = 4,
   parameter int A_W   = 18,
   parameter int B_W   = 19,
   parameter int OUT_W = 40
);
   logic                         in_valid;
   logic [LANES*TERMS*A_W-1:0]   in_a;
   logic [LANES*TERMS*B_W-1:0]   in_b;
   logic                         acc_en;
   logic                         acc_last;
   logic                         out_valid;
   logic [LANES*OUT_W-1:0]       outp;
   logic [LANES-1:0]             ovf;

   modport master (
      output in_valid, in_a, in_b, acc_en, acc_last,
      input  out_valid, outp, ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, acc_en, acc_last,
      output out_valid, outp, ovf
   );
endinterface

// File: rtl/dsp_chain_sop_array_lane.sv
// One lane: skewed operands, registered products, cascade adder chain, then accumulate/saturate.
// Result register lands TERMS+2 cycles after operand capture; no backpressure.
module dsp_sop_lane
   import dsp_sop_pkg::*;
#(
   parameter int TERMS    = 4,
   parameter int A_W      = 18,
   parameter int B_W      = 19,
   parameter int OUT_W    = 40,
   parameter int SATURATE = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [TERMS*A_W-1:0]   a,
   input  logic [TERMS*B_W-1:0]   b,
   input  ctrl_t                  res_ctrl,
   output logic [OUT_W-1:0]       outp,
   output logic                   ovf
);
   localparam int P_W     = A_W + B_W;
   localparam int CHAIN_W = chain_width(A_W, B_W, TERMS);
   localparam int SUM_W   = OUT_W + 1;

   logic signed [CHAIN_W-1:0] prod [TERMS];
   logic signed [CHAIN_W-1:0] casc [TERMS];

   // Term k waits k extra cycles so its product meets the cascade partial sum.
   for (genvar k = 0; k < TERMS; k++) begin : g_term
      logic signed [A_W-1:0]     a_d [k+1];
      logic signed [B_W-1:0]     b_d [k+1];
      logic signed [CHAIN_W-1:0] m_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            for (int d = 0; d <= k; d++) begin
               a_d[d] <= '0;
               b_d[d] <= '0;
            end
            m_q <= '0;
         end else begin
            a_d[0] <= a[k*A_W +: A_W];
            b_d[0] <= b[k*B_W +: B_W];
            for (int d = 1; d <= k; d++) begin
               a_d[d] <= a_d[d-1];
               b_d[d] <= b_d[d-1];
            end
            m_q <= CHAIN_W'(P_W'(a_d[k]) * P_W'(b_d[k]));
         end
      end

      assign prod[k] = m_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < TERMS; k++) casc[k] <= '0;
      end else begin
         casc[0] <= prod[0];
         for (int k = 1; k < TERMS; k++) casc[k] <= casc[k-1] + prod[k];
      end
   end

   logic signed [OUT_W-1:0] acc_q;
   logic signed [OUT_W-1:0] acc_in;
   logic signed [OUT_W-1:0] sum_ext;
   logic signed [SUM_W-1:0] add_w;
   logic [OUT_W-1:0]        add_res;
   logic                    ov_now;
   logic                    sticky_q;

   always_comb begin
      sum_ext = OUT_W'(casc[TERMS-1]);
      acc_in  = res_ctrl.acc_en ? acc_q : '0;
      add_w   = SUM_W'(acc_in) + SUM_W'(sum_ext);
      ov_now  = add_w[OUT_W] ^ add_w[OUT_W-1];
      add_res = add_w[OUT_W-1:0];
      if (ov_now && (SATURATE != 0)) begin
         add_res = add_w[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q    <= '0;
         sticky_q <= 1'b0;
         outp     <= '0;
         ovf      <= 1'b0;
      end else if (res_ctrl.valid) begin
         if (res_ctrl.acc_en && !res_ctrl.acc_last) begin
            acc_q    <= add_res;
            sticky_q <= sticky_q | ov_now;
         end else begin
            acc_q    <= '0;
            sticky_q <= 1'b0;
            outp     <= add_res;
            // A stray sticky bit from an abandoned group must not leak into a lone beat.
            ovf      <= ov_now | (res_ctrl.acc_en & sticky_q);
         end
      end
   end
endmodule

// File: rtl/dsp_chain_sop_array.sv
// LANES parallel sum-of-products lanes sharing one beat-control shift register; latency TERMS+2.
// No backpressure: a beat may be accepted every cycle and results are never stalled.
module dsp_chain_sop_array
   import dsp_sop_pkg::*;
#(
   parameter int LANES    = DEF_LANES,
   parameter int TERMS    = DEF_TERMS,
   parameter int A_W      = DEF_A_W,
   parameter int B_W      = DEF_B_W,
   parameter int OUT_W    = DEF_OUT_W,
   parameter int SATURATE = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   dsp_chain_sop_array_if.slave    bus
);
   localparam int L = sop_latency(TERMS);

   ctrl_t ctrl_sr [L];

   // Slot 0 is the input capture; slot L-1 lines up with the lanes' final cascade value.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < L; i++) ctrl_sr[i] <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         ctrl_sr[0] <= ctrl_t'{valid: bus.in_valid, acc_en: bus.acc_en, acc_last: bus.acc_last};
         for (int i = 1; i < L; i++) ctrl_sr[i] <= ctrl_sr[i-1];
         bus.out_valid <= ctrl_sr[L-1].valid & (~ctrl_sr[L-1].acc_en | ctrl_sr[L-1].acc_last);
      end
   end

   logic [LANES*OUT_W-1:0] outp_w;
   logic [LANES-1:0]       ovf_w;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      dsp_sop_lane #(
         .TERMS    (TERMS),
         .A_W      (A_W),
         .B_W      (B_W),
         .OUT_W    (OUT_W),
         .SATURATE (SATURATE)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .a        (bus.in_a[l*TERMS*A_W +: TERMS*A_W]),
         .b        (bus.in_b[l*TERMS*B_W +: TERMS*B_W]),
         .res_ctrl (ctrl_sr[L-1]),
         .outp     (outp_w[l*OUT_W +: OUT_W]),
         .ovf      (ovf_w[l])
      );
   end

   assign bus.outp = outp_w;
   assign bus.ovf  = ovf_w;
endmodule

// File: tb/tb_dsp_chain_sop_array.sv
// Directed bench driving a saturating and a wrapping instance with identical beats.
// A longint reference model pushes expected results; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_dsp_chain_sop_array;
   localparam int LANES = 8;
   localparam int TERMS = 4;
   localparam int A_W   = 18;
   localparam int B_W   = 19;
   localparam int OUT_W = 40;
   localparam int LAT   = 6;
   localparam longint MAXV = (longint'(1) <<< (OUT_W-1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (OUT_W-1));

   typedef struct {
      logic [LANES*OUT_W-1:0] o_s;
      logic [LANES*OUT_W-1:0] o_w;
      logic [LANES-1:0]       v_s;
      logic [LANES-1:0]       v_w;
      int                     cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dsp_chain_sop_array_if #(.LANES(LANES), .TERMS(TERMS), .A_W(A_W), .B_W(B_W), .OUT_W(OUT_W)) bus_s ();
   dsp_chain_sop_array_if #(.LANES(LANES), .TERMS(TERMS), .A_W(A_W), .B_W(B_W), .OUT_W(OUT_W)) bus_w ();

   dsp_chain_sop_array #(.LANES(LANES), .TERMS(TERMS), .A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .SATURATE(1))
      u_sat (.clk(clk), .reset(reset), .bus(bus_s));
   dsp_chain_sop_array #(.LANES(LANES), .TERMS(TERMS), .A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .SATURATE(0))
      u_wrap (.clk(clk), .reset(reset), .bus(bus_w));

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   exp_t q[$];

   int     ta  [LANES][TERMS];
   int     tbv [LANES][TERMS];
   longint acc_s [LANES];
   longint acc_w [LANES];
   bit     st_s  [LANES];
   bit     st_w  [LANES];

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [LANES*OUT_W-1:0] obs, input logic [LANES*OUT_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int l = 0; l < LANES; l++) begin
         acc_s[l] = 0; acc_w[l] = 0; st_s[l] = 1'b0; st_w[l] = 1'b0;
      end
   endtask

   task automatic clear_ops();
      for (int l = 0; l < LANES; l++)
         for (int t = 0; t < TERMS; t++) begin
            ta[l][t] = 0; tbv[l][t] = 0;
         end
   endtask

   // Lane 0: a={1,2,3,4}, b={5,6,7,8} gives 70.
   task automatic lane0_basic();
      clear_ops();
      for (int t = 0; t < TERMS; t++) begin
         ta[0][t]  = t + 1;
         tbv[0][t] = t + 5;
      end
   endtask

   task automatic idle(input int n);
      bus_s.in_valid = 1'b0; bus_w.in_valid = 1'b0;
      bus_s.acc_en   = 1'b0; bus_w.acc_en   = 1'b0;
      bus_s.acc_last = 1'b0; bus_w.acc_last = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      q.delete();
      model_clear();
      idle(n);
      reset = 1'b0;
   endtask

   task automatic drive_beat(input bit en, input bit last);
      logic [LANES*TERMS*A_W-1:0] va;
      logic [LANES*TERMS*B_W-1:0] vb;
      logic signed [OUT_W-1:0]    tr;
      exp_t   e;
      longint s, ns, nw;
      bit     os, ow;
      va = '0; vb = '0;
      for (int l = 0; l < LANES; l++)
         for (int t = 0; t < TERMS; t++) begin
            va[(l*TERMS+t)*A_W +: A_W] = A_W'(ta[l][t]);
            vb[(l*TERMS+t)*B_W +: B_W] = B_W'(tbv[l][t]);
         end
      bus_s.in_a = va; bus_w.in_a = va;
      bus_s.in_b = vb; bus_w.in_b = vb;
      bus_s.in_valid = 1'b1; bus_w.in_valid = 1'b1;
      bus_s.acc_en   = en;   bus_w.acc_en   = en;
      bus_s.acc_last = last; bus_w.acc_last = last;
      e.o_s = '0; e.o_w = '0; e.v_s = '0; e.v_w = '0;
      e.cyc = cyc + 1 + LAT;
      for (int l = 0; l < LANES; l++) begin
         s = 0;
         for (int t = 0; t < TERMS; t++) s += longint'(ta[l][t]) * longint'(tbv[l][t]);
         if (!en) begin
            ns = s; nw = s; os = 1'b0; ow = 1'b0;
         end else begin
            ns = acc_s[l] + s;
            nw = acc_w[l] + s;
            os = (ns > MAXV) || (ns < MINV);
            ow = (nw > MAXV) || (nw < MINV);
            if (ns > MAXV) ns = MAXV;
            else if (ns < MINV) ns = MINV;
            tr = nw[OUT_W-1:0];
            nw = longint'(tr);
            os = os | st_s[l];
            ow = ow | st_w[l];
         end
         if (en && !last) begin
            acc_s[l] = ns; acc_w[l] = nw; st_s[l] = os; st_w[l] = ow;
         end else begin
            acc_s[l] = 0; acc_w[l] = 0; st_s[l] = 1'b0; st_w[l] = 1'b0;
            e.o_s[l*OUT_W +: OUT_W] = ns[OUT_W-1:0];
            e.o_w[l*OUT_W +: OUT_W] = nw[OUT_W-1:0];
            e.v_s[l] = os;
            e.v_w[l] = ow;
         end
      end
      if (!en || last) q.push_back(e);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset !== 1'b1) begin
         if (bus_s.out_valid === 1'b1 || bus_w.out_valid === 1'b1 || (q.size() > 0 && cyc >= q[0].cyc)) begin
            chk("out_valid_sat", bus_s.out_valid, 1);
            chk("out_valid_wrap", bus_w.out_valid, 1);
            chk("result_expected", (q.size() != 0), 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("result_cycle", cyc, e.cyc);
               chk("outp_sat", bus_s.outp, e.o_s);
               chk("outp_wrap", bus_w.outp, e.o_w);
               chk("ovf_sat", bus_s.ovf, e.v_s);
               chk("ovf_wrap", bus_w.ovf, e.v_w);
            end
         end
      end
   end

   initial begin
      logic [LANES*OUT_W-1:0] hold70;
      reset = 1'b1;
      bus_s.in_a = '0; bus_w.in_a = '0;
      bus_s.in_b = '0; bus_w.in_b = '0;
      clear_ops();
      model_clear();
      idle(3);
      chk("reset_outp_sat", bus_s.outp, 0);
      chk("reset_outp_wrap", bus_w.outp, 0);
      chk("reset_ovf_sat", bus_s.ovf, 0);
      chk("reset_ovf_wrap", bus_w.ovf, 0);
      chk("reset_out_valid_sat", bus_s.out_valid, 0);
      chk("reset_out_valid_wrap", bus_w.out_valid, 0);
      reset = 1'b0;

      // Single beat, fixed latency, then outputs must hold.
      lane0_basic();
      drive_beat(1'b0, 1'b0);
      idle(10);
      hold70 = '0;
      hold70[OUT_W-1:0] = 70;
      chk("hold_outp_sat", bus_s.outp, hold70);
      chk("hold_out_valid_low", bus_s.out_valid, 0);

      // Ten back-to-back single beats.
      for (int beat = 0; beat < 10; beat++) begin
         for (int l = 0; l < LANES; l++)
            for (int t = 0; t < TERMS; t++) begin
               ta[l][t] = l + beat; tbv[l][t] = 1;
            end
         drive_beat(1'b0, 1'b0);
      end
      idle(10);

      // Three-beat group with a two-cycle bubble after the first beat.
      lane0_basic();
      drive_beat(1'b1, 1'b0);
      idle(2);
      drive_beat(1'b1, 1'b0);
      drive_beat(1'b1, 1'b1);
      idle(10);

      // Eight beats of 2^37 per lane: saturates on one instance, wraps to 0 on the other.
      for (int l = 0; l < LANES; l++)
         for (int t = 0; t < TERMS; t++) begin
            ta[l][t] = -131072; tbv[l][t] = -262144;
         end
      for (int i = 0; i < 8; i++) drive_beat(1'b1, (i == 7));
      idle(10);

      // Reset in the middle of a group, then a fresh single beat.
      lane0_basic();
      drive_beat(1'b1, 1'b0);
      drive_beat(1'b1, 1'b0);
      idle(2);
      do_reset(2);
      drive_beat(1'b0, 1'b0);
      idle(10);

      // Group closed by acc_last, immediately followed by a lone beat (acc_last ignored there).
      lane0_basic();
      drive_beat(1'b1, 1'b0);
      drive_beat(1'b1, 1'b1);
      clear_ops();
      ta[0][0] = 5; tbv[0][0] = 1;
      drive_beat(1'b0, 1'b1);
      idle(10);

      for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
      chk("results_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
